// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone B4 classic arbiter.
package wb_arb_pkg;

    localparam int NUM_MASTERS = 2;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    function automatic logic [NUM_MASTERS-1:0] grant_of(input arb_state_t s);
        case (s)
            GNT0:    return 2'b01;
            GNT1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts consecutive STB-without-ACK cycles and fires on the
// LIMIT-th one. Only instantiated when WB_ARB_TIMEOUT_EN is defined.
import wb_arb_pkg::*;

module wb_arb_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stb_i,
    input  logic ack_i,
    input  logic clear_i,
    output logic fire_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        stall;

    assign stall   = stb_i & ~ack_i;
    assign count_d = (clear_i || !stall) ? 16'd0 : count_q + 16'd1;

    // Fires combinationally during the stalled cycle that would be number LIMIT.
    assign fire_o  = stall && (count_q == 16'(LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous,
    // so it lives inside the clocked process rather than in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone B4 classic arbiter with CYC-tenure grants.
// Define WB_ARB_TIMEOUT_EN to build the stalled-transfer watchdog.
import wb_arb_pkg::*;

module wb_arbiter #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    M0_CYC_I,
    input  logic                    M0_STB_I,
    input  logic                    M0_WE_I,
    input  logic [DATA_WIDTH/8-1:0] M0_SEL_I,
    input  logic [ADDR_WIDTH-1:0]   M0_ADR_I,
    input  logic [DATA_WIDTH-1:0]   M0_DAT_I,
    output logic [DATA_WIDTH-1:0]   M0_DAT_O,
    output logic                    M0_ACK_O,
    input  logic                    M1_CYC_I,
    input  logic                    M1_STB_I,
    input  logic                    M1_WE_I,
    input  logic [DATA_WIDTH/8-1:0] M1_SEL_I,
    input  logic [ADDR_WIDTH-1:0]   M1_ADR_I,
    input  logic [DATA_WIDTH-1:0]   M1_DAT_I,
    output logic [DATA_WIDTH-1:0]   M1_DAT_O,
    output logic                    M1_ACK_O,
    output logic                    S_CYC_O,
    output logic                    S_STB_O,
    output logic                    S_WE_O,
    output logic [DATA_WIDTH/8-1:0] S_SEL_O,
    output logic [ADDR_WIDTH-1:0]   S_ADR_O,
    output logic [DATA_WIDTH-1:0]   S_DAT_O,
    input  logic [DATA_WIDTH-1:0]   S_DAT_I,
    input  logic                    S_ACK_I,
    output logic [1:0]              gnt_o,
    output logic                    timeout_o
);

    arb_state_t             state_q, state_d;
    logic                   last_owner_q, last_owner_d;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic                   wd_fire;

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_stb;
    logic wd_clear;
    logic timeout_q;

    assign wd_stb   = (state_q == GNT0) ? M0_STB_I :
                      (state_q == GNT1) ? M1_STB_I : 1'b0;
    assign wd_clear = (state_d != state_q);

    wb_arb_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stb_i   (wd_stb),
        .ack_i   (S_ACK_I),
        .clear_i (wd_clear),
        .fire_o  (wd_fire)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_q | wd_fire;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I) begin
                    state_d = last_owner_q ? GNT0 : GNT1;
                end else if (M0_CYC_I) begin
                    state_d = GNT0;
                end else if (M1_CYC_I) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!M0_CYC_I || wd_fire) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end
            GNT1: begin
                if (!M1_CYC_I || wd_fire) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            gnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= grant_of(state_d);
        end
    end

    assign gnt_o = gnt_q;

    // Owner pass-through; everything reads zero while reset is asserted.
    always_comb begin
        S_CYC_O  = 1'b0;
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_SEL_O  = '0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        M0_ACK_O = 1'b0;
        M0_DAT_O = '0;
        M1_ACK_O = 1'b0;
        M1_DAT_O = '0;
        if (rst_i) begin
            case (state_q)
                GNT0: begin
                    S_CYC_O  = M0_CYC_I;
                    S_STB_O  = M0_STB_I;
                    S_WE_O   = M0_WE_I;
                    S_SEL_O  = M0_SEL_I;
                    S_ADR_O  = M0_ADR_I;
                    S_DAT_O  = M0_DAT_I;
                    M0_ACK_O = wd_fire | S_ACK_I;
                    M0_DAT_O = wd_fire ? DATA_WIDTH'(TIMEOUT_DATA) : S_DAT_I;
                end
                GNT1: begin
                    S_CYC_O  = M1_CYC_I;
                    S_STB_O  = M1_STB_I;
                    S_WE_O   = M1_WE_I;
                    S_SEL_O  = M1_SEL_I;
                    S_ADR_O  = M1_ADR_I;
                    S_DAT_O  = M1_DAT_I;
                    M1_ACK_O = wd_fire | S_ACK_I;
                    M1_DAT_O = wd_fire ? DATA_WIDTH'(TIMEOUT_DATA) : S_DAT_I;
                end
                default: ;
            endcase
            if (wd_fire) begin
                S_CYC_O = 1'b0;
                S_STB_O = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; the watchdog section adapts to
// whether WB_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m1_ack;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [1:0]  gnt;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_gnt [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    always #5 clk = ~clk;

    wb_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .M0_CYC_I  (m0_cyc),
        .M0_STB_I  (m0_stb),
        .M0_WE_I   (m0_we),
        .M0_SEL_I  (m0_sel),
        .M0_ADR_I  (m0_adr),
        .M0_DAT_I  (m0_wdat),
        .M0_DAT_O  (m0_rdat),
        .M0_ACK_O  (m0_ack),
        .M1_CYC_I  (m1_cyc),
        .M1_STB_I  (m1_stb),
        .M1_WE_I   (m1_we),
        .M1_SEL_I  (m1_sel),
        .M1_ADR_I  (m1_adr),
        .M1_DAT_I  (m1_wdat),
        .M1_DAT_O  (m1_rdat),
        .M1_ACK_O  (m1_ack),
        .S_CYC_O   (s_cyc),
        .S_STB_O   (s_stb),
        .S_WE_O    (s_we),
        .S_SEL_O   (s_sel),
        .S_ADR_O   (s_adr),
        .S_DAT_O   (s_wdat),
        .S_DAT_I   (s_rdat),
        .S_ACK_I   (s_ack),
        .gnt_o     (gnt),
        .timeout_o (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = '0; m0_wdat = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = '0; m1_wdat = '0;
        s_ack  = 1'b0; s_rdat = '0;
    endtask

    task automatic go_idle();
        drop_all();
        tick();
        tick();
        check("idle_gnt", {30'd0, gnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        drop_all();

        // Reset held with both masters requesting and the slave acking.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_00A0; m0_sel = 4'hF;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_00B0; m1_sel = 4'hF;
        s_ack  = 1'b1; s_rdat = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt",   {30'd0, gnt}, 32'd0);
            check("rst_scyc",  {31'd0, s_cyc}, 32'd0);
            check("rst_sadr",  s_adr, 32'd0);
            check("rst_m0ack", {31'd0, m0_ack}, 32'd0);
            check("rst_m0dat", m0_rdat, 32'd0);
        end
        tick();
        s_ack = 1'b0;
        rst   = 1'b1;
        #1;
        check("rel_gnt_pre",  {30'd0, gnt}, 32'd0);
        check("rel_sstb_pre", {31'd0, s_stb}, 32'd0);
        tick();
        check("rel_gnt",     {30'd0, gnt}, 32'h1);
        check("rel_sadr",    s_adr, 32'h0000_00A0);
        check("rel_timeout", {31'd0, timeout}, 32'd0);
        go_idle();

        // Single M0 read; slave acks on the third granted cycle while M0 drops CYC.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 4'hF; m0_adr = 32'h0000_1000;
        #1;
        check("req_stb_held", {31'd0, s_stb}, 32'd0);
        tick();
        check("rd_gnt",    {30'd0, gnt}, 32'h1);
        check("rd_sstb",   {31'd0, s_stb}, 32'h1);
        check("rd_sadr",   s_adr, 32'h0000_1000);
        check("rd_wait1",  {31'd0, m0_ack}, 32'd0);
        tick();
        check("rd_wait2",  {31'd0, m0_ack}, 32'd0);
        check("rd_m1ack0", {31'd0, m1_ack}, 32'd0);
        tick();
        s_ack = 1'b1; s_rdat = 32'h1234_5678;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        check("rd_m0ack",  {31'd0, m0_ack}, 32'h1);
        check("rd_m0dat",  m0_rdat, 32'h1234_5678);
        check("rd_m1ack",  {31'd0, m1_ack}, 32'd0);
        check("rd_m1dat",  m1_rdat, 32'd0);
        check("rd_scyc",   {31'd0, s_cyc}, 32'd0);
        tick();
        check("idle_ack_gnt", {30'd0, gnt}, 32'd0);
        check("idle_ack_ign", {31'd0, m0_ack}, 32'd0);
        check("idle_dat_ign", m0_rdat, 32'd0);
        s_ack = 1'b0;

        // Contention after an M0 tenure: grants alternate starting with M1.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_2000; m0_wdat = 32'hAAAA_0000;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h0000_3000; m1_wdat = 32'hBBBB_0000;
        #1;
        check("ct_gnt_idle", {30'd0, gnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ct_gnt",  {30'd0, gnt}, {30'd0, exp_gnt[i]});
            check("ct_sadr", s_adr, (exp_gnt[i] == 2'b01) ? 32'h0000_2000 : 32'h0000_3000);
            check("ct_sdat", s_wdat, (exp_gnt[i] == 2'b01) ? 32'hAAAA_0000 : 32'hBBBB_0000);
            s_ack = 1'b1;
            if (exp_gnt[i] == 2'b01) begin
                m0_cyc = 1'b0; m0_stb = 1'b0;
            end else begin
                m1_cyc = 1'b0; m1_stb = 1'b0;
            end
            #1;
            check("ct_ack", {30'd0, m1_ack, m0_ack}, {30'd0, exp_gnt[i]});
            tick();
            s_ack  = 1'b0;
            m0_cyc = 1'b1; m0_stb = 1'b1;
            m1_cyc = 1'b1; m1_stb = 1'b1;
            #1;
            check("ct_dead", {30'd0, gnt}, 32'd0);
        end
        go_idle();

        // Non-preemption: M0 keeps CYC for three beats while M1 waits.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_4000;
        tick();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_5000;
        for (int b = 0; b < 3; b++) begin
            m0_adr = 32'h0000_4000 + 32'(b * 4);
            s_ack  = 1'b1;
            if (b == 2) begin
                m0_cyc = 1'b0; m0_stb = 1'b0;
            end
            #1;
            check("np_gnt",   {30'd0, gnt}, 32'h1);
            check("np_sadr",  s_adr, 32'h0000_4000 + 32'(b * 4));
            check("np_m0ack", {31'd0, m0_ack}, 32'h1);
            check("np_m1ack", {31'd0, m1_ack}, 32'd0);
            tick();
        end
        s_ack = 1'b0;
        #1;
        check("np_dead", {30'd0, gnt}, 32'd0);
        check("np_sadr_idle", s_adr, 32'd0);
        tick();
        check("np_m1_gnt", {30'd0, gnt}, 32'h2);
        check("np_m1_adr", s_adr, 32'h0000_5000);

        // Reset mid-transfer in GNT1; M0 must win the first contention afterwards.
        check("mid_scyc_pre", {31'd0, s_cyc}, 32'h1);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        rst    = 1'b0;
        s_ack  = 1'b1;
        tick();
        check("mid_scyc",  {31'd0, s_cyc}, 32'd0);
        check("mid_m1ack", {31'd0, m1_ack}, 32'd0);
        check("mid_gnt",   {30'd0, gnt}, 32'd0);
        tick();
        s_ack = 1'b0;
        rst   = 1'b1;
        tick();
        check("mid_m0_wins", {30'd0, gnt}, 32'h1);
        go_idle();

        // Slave never acks.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_6000;
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            #1;
            check("wd_stall_ack", {31'd0, m0_ack}, 32'd0);
            check("wd_stall_stb", {31'd0, s_stb}, 32'h1);
            tick();
        end
        #1;
        check("wd_fire_ack",  {31'd0, m0_ack}, 32'h1);
        check("wd_fire_dat",  m0_rdat, 32'hDEAD_BEEF);
        check("wd_fire_scyc", {31'd0, s_cyc}, 32'd0);
        check("wd_fire_sstb", {31'd0, s_stb}, 32'd0);
        tick();
        check("wd_idle_gnt", {30'd0, gnt}, 32'd0);
        check("wd_sticky1",  {31'd0, timeout}, 32'h1);
        tick();
        check("wd_regrant",  {30'd0, gnt}, 32'h1);
        go_idle();
        check("wd_sticky2",  {31'd0, timeout}, 32'h1);
`else
        for (int k = 1; k <= 12; k++) begin
            #1;
            check("hang_ack", {31'd0, m0_ack}, 32'd0);
            check("hang_gnt", {30'd0, gnt}, 32'h1);
            tick();
        end
        check("hang_timeout", {31'd0, timeout}, 32'd0);
        go_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
